simt_scheduler: RTL

- Successor to the single-PC core scheduler. It drives the same 8-state core FSM, but each thread keeps its own PC, so threads can branch divergently.
- Each cycle the block issues the minimum PC among live threads and asserts an active mask selecting the threads at that PC. Divergent threads reconverge as soon as their PCs meet again.
- Sits inside the compute core between the fetcher/decoder and the per-thread ALU/LSU/register/PC units. active_mask gates those per-thread units.

---
 rtl/simt_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/simt_scheduler.sv
// SIMT core scheduler: per-lane PCs, minimum-PC issue with reconvergence.
// Drives the 8-state core FSM; active_mask gates the per-lane execution units.

// One thread lane: holds its PC and retired flag.
module simt_lane #(
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         init_retired,
  input  logic         update,
  input  logic         active,
  input  logic         ret,
  input  logic [A-1:0] next_pc,
  output logic [A-1:0] pc,
  output logic         retired
);

  // Lane state moves only on kernel start or at the UPDATE edge for active lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      retired <= 1'b1;
    end else if (init) begin
      pc      <= '0;
      retired <= init_retired;
    end else if (update && active) begin
      if (ret) retired <= 1'b1;
      else     pc      <= next_pc;
    end
  end

endmodule

module simt_scheduler #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]                thread_count,
  input  logic [2:0]                                        fetcher_state,
  input  logic                                              decoded_mem_read_enable,
  input  logic                                              decoded_mem_write_enable,
  input  logic                                              decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]                    lsu_state,
  input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                                        core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                  current_pc,
  output logic [THREADS_PER_BLOCK-1:0]                      active_mask,
  output logic                                              done
);

  localparam int T  = THREADS_PER_BLOCK;
  localparam int A  = PROGRAM_MEM_ADDR_BITS;
  localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam logic [CW-1:0] T_MAX = CW'(T);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] REQUEST = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] EXECUTE = 3'd5;
  localparam logic [2:0] UPDATE  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam logic [2:0] FETCHED = 3'b010;

  logic [2:0]          state, state_nx;
  logic [CW-1:0]       cnt_q, cnt_eff;
  logic [T-1:0][A-1:0] lane_pc, lane_npc;
  logic [T-1:0][1:0]   lane_lsu;
  logic [T-1:0]        retired, lane_en, live, lane_busy, retired_after;
  logic                lane_init, lane_upd, mem_op, all_retired;
  logic [A-1:0]        pc_min;
  logic                found;

  assign lane_npc = next_pc;
  assign lane_lsu = lsu_state;

  // Oversized thread counts saturate at the lane count.
  assign cnt_eff   = (thread_count > T_MAX) ? T_MAX : thread_count;
  assign lane_init = (state == IDLE) && start && (cnt_eff != '0);
  assign lane_upd  = (state == UPDATE);
  assign mem_op    = decoded_mem_read_enable | decoded_mem_write_enable;

  genvar g;
  generate
    for (g = 0; g < T; g++) begin : g_lane
      simt_lane #(.A(A)) u_lane (
        .clk          (clk),
        .reset        (reset),
        .init         (lane_init),
        .init_retired (CW'(g) >= cnt_eff),
        .update       (lane_upd),
        .active       (active_mask[g]),
        .ret          (decoded_ret),
        .next_pc      (lane_npc[g]),
        .pc           (lane_pc[g]),
        .retired      (retired[g])
      );
      // A lane stalls WAIT only while it is active and its LSU is requesting/waiting.
      assign lane_busy[g] = active_mask[g] &&
                            ((lane_lsu[g] == 2'd1) || (lane_lsu[g] == 2'd2));
    end
  endgenerate

  // Lanes beyond the latched count are never live, even if a retired bit were lost.
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < T; i++) lane_en[i] = (CW'(i) < cnt_q);
  end

  assign live = ~retired & lane_en;

  // Unsigned minimum over live lanes; ties all join the active mask.
  always_comb begin
    pc_min = '0;
    found  = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (live[i] && (!found || (lane_pc[i] < pc_min))) begin
        pc_min = lane_pc[i];
        found  = 1'b1;
      end
    end
  end

  // Lanes sitting at the issued PC execute this instruction.
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < T; i++) active_mask[i] = live[i] && (lane_pc[i] == pc_min);
  end

  assign current_pc    = pc_min;
  assign retired_after = retired | (decoded_ret ? active_mask : '0);
  assign all_retired   = &(retired_after | ~lane_en);

  // Core FSM next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (cnt_eff == '0) ? DONE : FETCH;
      FETCH:   if (fetcher_state == FETCHED) state_nx = DECODE;
      DECODE:  state_nx = REQUEST;
      REQUEST: state_nx = WAIT;
      WAIT:    if (!mem_op || !(|lane_busy)) state_nx = EXECUTE;
      EXECUTE: state_nx = UPDATE;
      UPDATE:  state_nx = all_retired ? DONE : FETCH;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and thread count latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (lane_init) cnt_q <= cnt_eff;
    end
  end

  assign core_state = state;
  assign done       = (state == DONE);

endmodule
